// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC vector-norm sequencer.
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } norm_state_t;

    localparam int NORM_DW = 16;
    localparam logic [NORM_DW-1:0] NORM_SAT_MAX = {1'b0, {(NORM_DW-1){1'b1}}};
    localparam logic [NORM_DW-1:0] NORM_SAT_MIN = {1'b1, {(NORM_DW-1){1'b0}}};

    localparam int MR_DIR_W = 16;

    typedef struct packed {
        logic [1:0]          quad;
        logic [MR_DIR_W-1:0] dir;
    } mr_entry_t;

endpackage

// File: rtl/cordic_sat_abs.sv
// Combinational magnitude clamp: absolute value of a signed input (abs mode) or
// pass-through that treats a set MSB as overflow (clamp mode); both saturate to max.
module cordic_sat_abs
    import cordic_pkg::*;
#(
    parameter int W = NORM_DW
) (
    input  logic [W-1:0] val_i,
    input  logic         abs_mode_i,
    output logic [W-1:0] mag_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] MAXV = (W == NORM_DW) ? W'(NORM_SAT_MAX) : {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = (W == NORM_DW) ? W'(NORM_SAT_MIN) : {1'b1, {(W-1){1'b0}}};

    always_comb begin
        mag_o = val_i;
        ovf_o = 1'b0;
        if (val_i[W-1]) begin
            if (abs_mode_i && (val_i != MINV)) begin
                mag_o = -val_i;
            end else begin
                mag_o = MAXV;
                ovf_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_vec_norm_seq.sv
// Sequencer folding a streamed vector into a running CORDIC vectoring magnitude.
// Define MICROROT_STORE_EN to buffer each step's {quad, dir} for a later replay pass.
module cordic_vec_norm_seq
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int MAX_DIM       = 8,
    parameter int DIM_W         = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     start,
    input  logic [DIM_W-1:0]         dim,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     err,
    output logic                     norm_valid,
    output logic [DATA_WIDTH-1:0]    norm_out,
    output logic                     norm_ovf,
    output logic                     cordic_vec_en,
    output logic [DATA_WIDTH-1:0]    cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]    cordic_vec_yin,
    output logic                     cordic_vec_angle_calc_en,
    input  logic                     cordic_vec_opvld,
    input  logic [DATA_WIDTH-1:0]    cordic_vec_xout,
    input  logic [CORDIC_STAGES-1:0] vec_microRot_dir,
    input  logic [1:0]               vec_quad,
    input  logic                     vec_microRot_out_start,
`ifdef MICROROT_STORE_EN
    input  logic [DIM_W-1:0]         mr_rd_addr,
    output logic [CORDIC_STAGES-1:0] mr_rd_dir,
    output logic [1:0]               mr_rd_quad,
    output logic [DIM_W-1:0]         mr_count,
`endif
    output norm_state_t              dbg_state_o
);

    norm_state_t           state_q, state_d;
    logic [DIM_W-1:0]      dim_q, dim_d, step_q, step_d;
    logic [DATA_WIDTH-1:0] r_q, r_d, xin_q, xin_d, yin_q, yin_d, norm_out_q;
    logic                  ovf_q, ovf_d, err_d, err_q;
    logic                  busy_q, in_ready_q, vec_en_q, norm_valid_q, norm_ovf_q;
    logic [DATA_WIDTH-1:0] sat_in, sat_mag;
    logic                  sat_abs_mode, sat_ovf;
    logic                  dim_legal, in_hs;

    assign dim_legal = (dim != '0) && (dim <= DIM_W'(MAX_DIM));
    assign in_hs     = in_valid && in_ready_q;

    cordic_sat_abs #(.W(DATA_WIDTH)) u_sat (
        .val_i      (sat_in),
        .abs_mode_i (sat_abs_mode),
        .mag_o      (sat_mag),
        .ovf_o      (sat_ovf)
    );

    always_comb begin
        state_d      = state_q;
        dim_d        = dim_q;
        step_d       = step_q;
        r_d          = r_q;
        ovf_d        = ovf_q;
        xin_d        = xin_q;
        yin_d        = yin_q;
        err_d        = 1'b0;
        sat_in       = in_data;
        sat_abs_mode = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (dim_legal) begin
                        dim_d   = dim;
                        step_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_hs) begin
                    if (dim_q == DIM_W'(1)) begin
                        r_d     = sat_mag;
                        ovf_d   = ovf_q | sat_ovf;
                        state_d = DONE;
                    end else begin
                        r_d     = in_data;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (in_hs) begin
                    xin_d   = r_q;
                    yin_d   = in_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // The CORDIC magnitude is unsigned in spirit; a set MSB means it overflowed.
                sat_in       = cordic_vec_xout;
                sat_abs_mode = 1'b0;
                if (cordic_vec_opvld) begin
                    r_d     = sat_mag;
                    ovf_d   = ovf_q | sat_ovf;
                    step_d  = step_q + DIM_W'(1);
                    state_d = (step_d == dim_q - DIM_W'(1)) ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dim_q        <= '0;
            step_q       <= '0;
            r_q          <= '0;
            ovf_q        <= 1'b0;
            xin_q        <= '0;
            yin_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            vec_en_q     <= 1'b0;
            norm_valid_q <= 1'b0;
            norm_ovf_q   <= 1'b0;
            norm_out_q   <= '0;
        end else begin
            dim_q        <= dim_d;
            step_q       <= step_d;
            r_q          <= r_d;
            ovf_q        <= ovf_d;
            xin_q        <= xin_d;
            yin_q        <= yin_d;
            err_q        <= err_d;
            busy_q       <= (state_d != IDLE);
            in_ready_q   <= (state_d == LOAD) || (state_d == FETCH);
            vec_en_q     <= (state_d == ISSUE);
            norm_valid_q <= (state_d == DONE);
            norm_ovf_q   <= (state_d == DONE) && ovf_d;
            if (state_d == DONE) begin
                norm_out_q <= r_d;
            end
        end
    end

    assign in_ready                 = in_ready_q;
    assign busy                     = busy_q;
    assign err                      = err_q;
    assign norm_valid               = norm_valid_q;
    assign norm_out                 = norm_out_q;
    assign norm_ovf                 = norm_ovf_q;
    assign cordic_vec_en            = vec_en_q;
    assign cordic_vec_xin           = xin_q;
    assign cordic_vec_yin           = yin_q;
    assign cordic_vec_angle_calc_en = 1'b0;
    assign dbg_state_o              = state_q;

    logic        unused_inputs;
    logic [31:0] unused_angle_w;
    assign unused_angle_w = 32'(ANGLE_WIDTH);

`ifdef MICROROT_STORE_EN
    localparam int MR_DEPTH = MAX_DIM - 1;
    localparam int MR_AW    = (MR_DEPTH > 1) ? $clog2(MR_DEPTH) : 1;

    mr_entry_t mr_mem [MR_DEPTH];
    mr_entry_t mr_rd_ent;

    // Not reset: contents stay valid until the next job overwrites them.
    always_ff @(posedge clk) begin
        if ((state_q == WAIT) && cordic_vec_opvld) begin
            mr_mem[step_q[MR_AW-1:0]] <= '{quad: vec_quad, dir: MR_DIR_W'(vec_microRot_dir)};
        end
    end

    always_comb begin
        mr_rd_ent = '0;
        if (mr_rd_addr < DIM_W'(MR_DEPTH)) begin
            mr_rd_ent = mr_mem[mr_rd_addr[MR_AW-1:0]];
        end
    end

    assign mr_rd_dir     = CORDIC_STAGES'(mr_rd_ent.dir);
    assign mr_rd_quad    = mr_rd_ent.quad;
    assign mr_count      = step_q;
    assign unused_inputs = vec_microRot_out_start;
`else
    assign unused_inputs = ^{vec_microRot_out_start, vec_quad, vec_microRot_dir};
`endif

endmodule

// File: tb/tb_cordic_vec_norm_seq.sv
// Bench for cordic_vec_norm_seq with a behavioural L-cycle CORDIC vectoring model.
module tb_cordic_vec_norm_seq;
    import cordic_pkg::*;

    localparam int DW   = 16;
    localparam int NS   = 16;
    localparam int DIMW = 4;
    localparam int L    = 16;

    // clock / reset
    logic clk = 1'b0;
    logic nreset = 1'b1;
    always #5 clk = ~clk;

    logic                 start, in_valid, in_ready, busy, err, norm_valid, norm_ovf;
    logic [DIMW-1:0]      dim;
    logic signed [DW-1:0] in_data;
    logic [DW-1:0]        norm_out, cordic_vec_xin, cordic_vec_yin, cordic_vec_xout;
    logic                 cordic_vec_en, cordic_vec_angle_calc_en, cordic_vec_opvld;
    logic [NS-1:0]        vec_microRot_dir;
    logic [1:0]           vec_quad;
    norm_state_t          dbg_state;
`ifdef MICROROT_STORE_EN
    logic [DIMW-1:0]      mr_rd_addr, mr_count;
    logic [NS-1:0]        mr_rd_dir;
    logic [1:0]           mr_rd_quad;
`endif

    cordic_vec_norm_seq #(
        .DATA_WIDTH(DW), .ANGLE_WIDTH(16), .CORDIC_STAGES(NS), .MAX_DIM(8), .DIM_W(DIMW)
    ) dut (
        .clk(clk), .nreset(nreset), .start(start), .dim(dim),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .err(err), .norm_valid(norm_valid), .norm_out(norm_out), .norm_ovf(norm_ovf),
        .cordic_vec_en(cordic_vec_en), .cordic_vec_xin(cordic_vec_xin), .cordic_vec_yin(cordic_vec_yin),
        .cordic_vec_angle_calc_en(cordic_vec_angle_calc_en),
        .cordic_vec_opvld(cordic_vec_opvld), .cordic_vec_xout(cordic_vec_xout),
        .vec_microRot_dir(vec_microRot_dir), .vec_quad(vec_quad),
        .vec_microRot_out_start(1'b0),
`ifdef MICROROT_STORE_EN
        .mr_rd_addr(mr_rd_addr), .mr_rd_dir(mr_rd_dir), .mr_rd_quad(mr_rd_quad), .mr_count(mr_count),
`endif
        .dbg_state_o(dbg_state)
    );

    // behavioural CORDIC vectoring: rounded magnitude after L cycles, random dir/quad
    function automatic logic [DW-1:0] cordic_mag(input logic [DW-1:0] x, input logic [DW-1:0] y);
        longint sx, sy;
        real    m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m  = $sqrt(real'(sx * sx + sy * sy));
        return DW'(longint'(m));
    endfunction

    logic [L-1:0]  pv = '0;
    logic [DW-1:0] pd [L];
    logic [NS-1:0] pdir [L];
    logic [1:0]    pq [L];
    logic [NS-1:0] last_dir = '0;
    logic [1:0]    last_quad = '0;

    always @(posedge clk) begin
        pv      <= {pv[L-2:0], cordic_vec_en};
        pd[0]   <= cordic_mag(cordic_vec_xin, cordic_vec_yin);
        pdir[0] <= NS'($urandom);
        pq[0]   <= 2'($urandom_range(0, 3));
        for (int i = 1; i < L; i++) begin
            pd[i]   <= pd[i-1];
            pdir[i] <= pdir[i-1];
            pq[i]   <= pq[i-1];
        end
        if (pv[L-1]) begin
            last_dir  <= pdir[L-1];
            last_quad <= pq[L-1];
        end
    end

    assign cordic_vec_opvld = pv[L-1];
    assign cordic_vec_xout  = pd[L-1];
    assign vec_microRot_dir = pdir[L-1];
    assign vec_quad         = pq[L-1];

    // scoreboard
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [DW:0] exp_q[$];
    int          tol_q[$];
    longint      cyc = 0;
    longint      last_valid_cyc = 0;
    int          done_cnt = 0;
    int          ops_cnt = 0;
    int          err_cnt = 0;
    int          busy_cnt = 0;
    int          rdy_viol = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nreset) begin
            if (cordic_vec_en) ops_cnt++;
            if (err) err_cnt++;
            if (busy) busy_cnt++;
            if ((dbg_state == WAIT) && in_ready) rdy_viol++;
            if (norm_valid) begin
                done_cnt++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected norm_valid", longint'(norm_out), -1);
                end else begin
                    logic [DW:0] e;
                    int          t;
                    int          diff;
                    e    = exp_q.pop_front();
                    t    = tol_q.pop_front();
                    diff = int'(norm_out) - int'(e[DW-1:0]);
                    if (diff < 0) diff = -diff;
                    chk(diff <= t, "norm_out", longint'(norm_out), longint'(e[DW-1:0]));
                    chk(norm_ovf == e[DW], "norm_ovf", longint'(norm_ovf), longint'(e[DW]));
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0]       dim;
        logic [7:0][15:0] elems;
        logic [3:0]       gap;
        logic [15:0]      exp_norm;
        logic [1:0]       tol;
        logic             exp_ovf;
        logic             poke;
    } vec_t;

    function automatic vec_t mk(input int d, input int e0, input int e1, input int e2, input int e3,
                                input int e4, input int e5, input int e6, input int e7,
                                input int gap, input int en, input int tol, input bit ovf, input bit poke);
        vec_t v;
        v.dim = 4'(d);
        v.elems[0] = 16'(e0); v.elems[1] = 16'(e1); v.elems[2] = 16'(e2); v.elems[3] = 16'(e3);
        v.elems[4] = 16'(e4); v.elems[5] = 16'(e5); v.elems[6] = 16'(e6); v.elems[7] = 16'(e7);
        v.gap = 4'(gap);
        v.exp_norm = 16'(en);
        v.tol = 2'(tol);
        v.exp_ovf = ovf;
        v.poke = poke;
        return v;
    endfunction

    // driver tasks
    task automatic drive_elem(input logic [DW-1:0] d);
        int c;
        c = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk(in_ready == 1'b1, "in_ready wait", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int c;
        c = 0;
        while (done_cnt == prev && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk(done_cnt != prev, "norm_valid timeout", longint'(c), 3000);
    endtask

    task automatic check_all_zero(input string tag);
        chk(in_ready == 1'b0, {tag, " in_ready"}, longint'(in_ready), 0);
        chk(busy == 1'b0, {tag, " busy"}, longint'(busy), 0);
        chk(err == 1'b0, {tag, " err"}, longint'(err), 0);
        chk(norm_valid == 1'b0, {tag, " norm_valid"}, longint'(norm_valid), 0);
        chk(norm_out == '0, {tag, " norm_out"}, longint'(norm_out), 0);
        chk(norm_ovf == 1'b0, {tag, " norm_ovf"}, longint'(norm_ovf), 0);
        chk(cordic_vec_en == 1'b0, {tag, " vec_en"}, longint'(cordic_vec_en), 0);
        chk(cordic_vec_xin == '0, {tag, " xin"}, longint'(cordic_vec_xin), 0);
        chk(cordic_vec_yin == '0, {tag, " yin"}, longint'(cordic_vec_yin), 0);
        chk(dbg_state == IDLE, {tag, " state"}, longint'(dbg_state), longint'(IDLE));
    endtask

    task automatic run_job(input vec_t v);
        int     prev;
        int     nd;
        longint t0;
        nd = int'(v.dim);
        ops_cnt  = 0;
        err_cnt  = 0;
        rdy_viol = 0;
        exp_q.push_back({v.exp_ovf, v.exp_norm});
        tol_q.push_back(int'(v.tol));
        prev  = done_cnt;
        start = 1'b1;
        dim   = v.dim;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < nd; k++) begin
            repeat (int'(v.gap)) begin
                @(posedge clk); #1;
            end
            drive_elem(v.elems[k]);
        end
        if (v.poke) begin
            repeat (3) begin
                @(posedge clk); #1;
            end
            start = 1'b1;
            dim   = 4'd0;
            @(posedge clk); #1;
            dim   = 4'd2;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(prev);
        chk(busy == 1'b0, "busy after done", longint'(busy), 0);
        if (v.gap == 0)
            chk(last_valid_cyc - t0 == longint'(2 + (nd - 1) * (L + 2)), "job latency",
                last_valid_cyc - t0, longint'(2 + (nd - 1) * (L + 2)));
        chk(ops_cnt == nd - 1, "vec_en pulses", longint'(ops_cnt), longint'(nd - 1));
        chk(err_cnt == 0, "err during job", longint'(err_cnt), 0);
        chk(rdy_viol == 0, "in_ready in WAIT", longint'(rdy_viol), 0);
`ifdef MICROROT_STORE_EN
        chk(mr_count == 4'(nd - 1), "mr_count", longint'(mr_count), longint'(nd - 1));
        if (nd > 1) begin
            mr_rd_addr = 4'(nd - 2);
            #1;
            chk(mr_rd_dir == last_dir, "mr_rd_dir last", longint'(mr_rd_dir), longint'(last_dir));
            chk(mr_rd_quad == last_quad, "mr_rd_quad last", longint'(mr_rd_quad), longint'(last_quad));
        end
`endif
    endtask

    task automatic err_case(input logic [DIMW-1:0] d);
        err_cnt  = 0;
        busy_cnt = 0;
        start = 1'b1;
        dim   = d;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk(err_cnt == 1, "err pulse count", longint'(err_cnt), 1);
        chk(busy_cnt == 0, "busy on bad dim", longint'(busy_cnt), 0);
    endtask

    vec_t tbl [7];

    initial begin
        int c;
        int prev;
        start = 1'b0; dim = '0; in_valid = 1'b0; in_data = '0;
`ifdef MICROROT_STORE_EN
        mr_rd_addr = '0;
`endif
        tbl[0] = mk(2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1'b0, 1'b0);
        tbl[1] = mk(4, 100, 100, 100, 100, 0, 0, 0, 0, 3, 200, 1, 1'b0, 1'b0);
        tbl[2] = mk(1, -32768, 0, 0, 0, 0, 0, 0, 0, 0, 32767, 0, 1'b1, 1'b0);
        tbl[3] = mk(2, 32767, 32767, 0, 0, 0, 0, 0, 0, 0, 32767, 0, 1'b1, 1'b1);
        tbl[4] = mk(2, -5, 12, 0, 0, 0, 0, 0, 0, 0, 13, 0, 1'b0, 1'b0);
        tbl[5] = mk(8, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 0, 2828, 1, 1'b0, 1'b0);
        tbl[6] = mk(3, 2, 3, 6, 0, 0, 0, 0, 0, 0, 7, 1, 1'b0, 1'b0);

        #2 nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("power-on reset");
        nreset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_job(tbl[i]);

        err_case(4'd0);
        err_case(4'd9);

        // reset while a vectoring op is in flight
        start = 1'b1; dim = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        drive_elem(16'd1000);
        drive_elem(16'd1000);
        c = 0;
        while (dbg_state != WAIT && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk(dbg_state == WAIT, "reached WAIT", longint'(dbg_state), longint'(WAIT));
        repeat (2) begin
            @(posedge clk); #1;
        end
        nreset = 1'b0;
        #1;
        check_all_zero("reset in WAIT");
        repeat (4) @(posedge clk);
        #1;
        nreset = 1'b1;

        exp_q.push_back({1'b0, 16'd10});
        tol_q.push_back(0);
        ops_cnt = 0;
        prev = done_cnt;
        start = 1'b1; dim = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!cordic_vec_opvld && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        chk(cordic_vec_opvld == 1'b1, "stale opvld seen", longint'(c), 40);
        @(posedge clk); #1;
        chk(dbg_state == LOAD, "stale opvld ignored", longint'(dbg_state), longint'(LOAD));
        drive_elem(16'd6);
        drive_elem(16'd8);
        wait_done(prev);
        chk(ops_cnt == 1, "post-reset vec_en", longint'(ops_cnt), 1);
`ifdef MICROROT_STORE_EN
        mr_rd_addr = '0;
        #1;
        chk(mr_count == 4'd1, "post-reset mr_count", longint'(mr_count), 1);
        chk(mr_rd_dir == last_dir, "mr_rd_dir[0]", longint'(mr_rd_dir), longint'(last_dir));
        chk(mr_rd_quad == last_quad, "mr_rd_quad[0]", longint'(mr_rd_quad), longint'(last_quad));
`endif

        chk(exp_q.size() == 0, "results outstanding", longint'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout, want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
